haz_scoreboard: RTL and testbench
=================================

# haz_scoreboard

Parametrised hazard unit for the MIPS core pipeline; successor to the fixed decode/exec/mem hazard packet exchange. Tracks every in-flight destination register over a configurable number of post-decode stages and produces decode stall/bubble and per-operand forwarding selects. Also adds a multi-cycle MDU (HI/LO) busy tracker and a configurable branch-resolution flush. Sits between decode and the exec/mem/wb stages, one instance per core.

## Interface
Parameters:
- REG_W, 5, register index width (matches reg_t)
- DEPTH, 4, tracked stages after decode; entry 1 = exec, entry DEPTH = writeback
- JMP_STAGE, 2, stage resolving jumps (2 = mem); legal range 2..DEPTH
- MDU_LAT, 32, MDU result latency in cycles after the op reaches JMP_STAGE
- SEL_W, $clog2(DEPTH+1), forwarding select width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dec_vld  in  1  decode holds a valid instruction
- dec_rs_vld / dec_rt_vld  in  1  operand read
- dec_rs / dec_rt  in  REG_W  source registers
- dec_dst_vld  in  1  writes a GPR
- dec_dst  in  REG_W  destination register
- dec_is_load  in  1  result produced in mem, not exec
- dec_mdu_op  in  1  mult/div start
- dec_mdu_rd  in  1  reads HI/LO (mfhi/mflo)
- mem_jmp_vld  in  1  jump/branch taken, resolved at JMP_STAGE
- stall  out  1  hold fetch/decode
- bubble  out  1  inject nop into exec
- fwd_rs_sel / fwd_rt_sel  out  SEL_W  0 = register file, k = entry k
- mdu_busy  out  1  MDU result outstanding

## Operation
- Scoreboard: DEPTH entries {vld, dst, load, mdu}, entry 1 youngest. Every cycle entries shift k -> k+1; entry DEPTH retires. Later stages never stall.
- Entry 1 captures decode iff dec_vld && !stall && !flush; otherwise written invalid (the bubble).
- Match on entry k: entry vld && dst_vld-origin && dst == src && src != 0 && src operand vld. Register 0 never matches.
- Load-use: match on entry 1 with load=1 -> stall.
- Forwarding: select = smallest k in 1..DEPTH-1 with a match (youngest wins); load at entry 1 excluded (stalled). Match only at DEPTH -> 0 (register file write-before-read).
- MDU: counter loads MDU_LAT when an entry with mdu=1 shifts into JMP_STAGE; decrements to 0. mdu_busy = counter != 0 || any entry 1..JMP_STAGE-1 has mdu=1. dec_mdu_rd or dec_mdu_op while mdu_busy -> stall.
- Flush (mem_jmp_vld): entries 1..JMP_STAGE-1 invalidated on the clock edge (their mdu bits dropped, counter unaffected); decode instruction not captured; stall forced 0; bubble=1.
- bubble = stall || mem_jmp_vld.

## Timing
- stall, bubble, fwd_*_sel combinational from decode inputs and registered scoreboard; zero-cycle latency.
- Scoreboard and counter update on rising clk.
- Load followed immediately by consumer: exactly 1 stall cycle, then fwd_sel = 2.
- Reset (any time, async): all entries invalid, counter 0. Outputs with idle decode: stall=0, bubble=0, fwd_*_sel=0, mdu_busy=0. Reset mid-MDU drops the op.
- Flush and load-use same cycle: flush wins (stall=0, bubble=1).
- Counter reload while nonzero cannot occur (second MDU op stalled).

## Configuration
- HAZ_FWD_EN defined: forwarding as above; only load-use and MDU stalls.
- Undefined: fwd_*_sel tied 0; any match on entries 1..DEPTH-1 stalls until producer reaches DEPTH.

## Test plan
- After reset, add $1,$2,$3 at decode -> stall=0, bubble=0, sels=0, mdu_busy=0.
- add $5 then sub $6,$5,$5 back-to-back -> fwd_rs_sel=fwd_rt_sel=1, no stall; without HAZ_FWD_EN -> 3 stall cycles (DEPTH=4).
- lw $4 then add $7,$4,$0 -> 1 stall + bubble, next cycle fwd_rs_sel=2; write to $0 followed by read $0 -> no stall, sel 0.
- mult then mfhi (MDU_LAT=4) -> mfhi stalls until counter expires, mdu_busy drops after 2+4 cycles, then issues.
- mem_jmp_vld with lw in entry 1 and dependent at decode -> bubble=1, stall=0, entry 1 invalid next cycle, no subsequent stall.
- rst_n asserted mid-MDU and with full scoreboard -> all outputs 0 immediately, clean issue after deassert.

Source files
------------

// File: rtl/haz_scoreboard_if.sv
// Decode <-> hazard-unit bundle: decode-stage instruction fields in, stall/bubble/forwarding out.
interface haz_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int SEL_W = 3
);
    logic             dec_vld;
    logic             dec_rs_vld;
    logic             dec_rt_vld;
    logic [REG_W-1:0] dec_rs;
    logic [REG_W-1:0] dec_rt;
    logic             dec_dst_vld;
    logic [REG_W-1:0] dec_dst;
    logic             dec_is_load;
    logic             dec_mdu_op;
    logic             dec_mdu_rd;
    logic             mem_jmp_vld;
    logic             stall;
    logic             bubble;
    logic [SEL_W-1:0] fwd_rs_sel;
    logic [SEL_W-1:0] fwd_rt_sel;
    logic             mdu_busy;

    modport master (
        output dec_vld, dec_rs_vld, dec_rt_vld, dec_rs, dec_rt, dec_dst_vld, dec_dst,
               dec_is_load, dec_mdu_op, dec_mdu_rd, mem_jmp_vld,
        input  stall, bubble, fwd_rs_sel, fwd_rt_sel, mdu_busy
    );

    modport slave (
        input  dec_vld, dec_rs_vld, dec_rt_vld, dec_rs, dec_rt, dec_dst_vld, dec_dst,
               dec_is_load, dec_mdu_op, dec_mdu_rd, mem_jmp_vld,
        output stall, bubble, fwd_rs_sel, fwd_rt_sel, mdu_busy
    );
endinterface

// File: rtl/haz_scoreboard.sv
// Pipeline hazard scoreboard: in-flight destination tracking, MDU busy, branch flush.
// Define HAZ_FWD_EN for operand forwarding; without it every RAW hazard stalls decode.
module haz_scoreboard #(
    parameter int REG_W     = 5,
    parameter int DEPTH     = 4,
    parameter int JMP_STAGE = 2,
    parameter int MDU_LAT   = 32,
    parameter int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    haz_scoreboard_if.slave hz
);
    localparam int CNT_W = $clog2(MDU_LAT + 1);

    typedef struct packed {
        logic             vld;
        logic             wr;
        logic [REG_W-1:0] dst;
        logic             load;
        logic             mdu;
    } entry_t;

    entry_t [DEPTH:1] sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:1] rs_hit, rt_hit;
    logic             rs_use, rt_use, flush;
    logic             load_use, mdu_busy, mdu_hz, stall;
    logic             sb_unused;

    assign flush  = hz.mem_jmp_vld;
    assign rs_use = hz.dec_vld && hz.dec_rs_vld && (hz.dec_rs != '0);
    assign rt_use = hz.dec_vld && hz.dec_rt_vld && (hz.dec_rt != '0);

    // NOTE: every always_comb output gets a default before any branch, so no latch can form.
    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int k = 1; k <= DEPTH - 1; k++) begin
            rs_hit[k] = rs_use && sb_q[k].vld && sb_q[k].wr && (sb_q[k].dst == hz.dec_rs);
            rt_hit[k] = rt_use && sb_q[k].vld && sb_q[k].wr && (sb_q[k].dst == hz.dec_rt);
        end
        load_use = sb_q[1].load && (rs_hit[1] || rt_hit[1]);
        mdu_busy = (cnt_q != '0);
        for (int k = 1; k <= JMP_STAGE - 1; k++) begin
            if (sb_q[k].mdu) mdu_busy = 1'b1;
        end
        mdu_hz = hz.dec_vld && (hz.dec_mdu_rd || hz.dec_mdu_op) && mdu_busy;
`ifdef HAZ_FWD_EN
        stall = !flush && (load_use || mdu_hz);
`else
        stall = !flush && (load_use || mdu_hz || (|rs_hit) || (|rt_hit));
`endif
    end

`ifdef HAZ_FWD_EN
    logic [DEPTH-1:1] rs_fwd, rt_fwd;
    logic [SEL_W-1:0] rs_sel, rt_sel;

    // Scan oldest to youngest so the youngest producer overrides; a load at entry 1 is stalled instead.
    always_comb begin
        rs_fwd    = rs_hit;
        rt_fwd    = rt_hit;
        rs_fwd[1] = rs_hit[1] && !sb_q[1].load;
        rt_fwd[1] = rt_hit[1] && !sb_q[1].load;
        rs_sel    = '0;
        rt_sel    = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (rs_fwd[k]) rs_sel = SEL_W'(k);
            if (rt_fwd[k]) rt_sel = SEL_W'(k);
        end
    end

    assign hz.fwd_rs_sel = rs_sel;
    assign hz.fwd_rt_sel = rt_sel;
`else
    assign hz.fwd_rs_sel = '0;
    assign hz.fwd_rt_sel = '0;
`endif

    always_comb begin
        sb_d = '0;
        if (hz.dec_vld && !stall && !flush) begin
            sb_d[1].vld  = 1'b1;
            sb_d[1].wr   = hz.dec_dst_vld;
            sb_d[1].dst  = hz.dec_dst;
            sb_d[1].load = hz.dec_is_load;
            sb_d[1].mdu  = hz.dec_mdu_op;
        end
        // Younger-than-branch entries are squashed as they advance; older ones keep going.
        for (int k = 2; k <= DEPTH; k++) begin
            if (!(flush && (k - 1) < JMP_STAGE)) sb_d[k] = sb_q[k-1];
        end
        cnt_d = cnt_q;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (sb_d[JMP_STAGE].mdu) cnt_d = CNT_W'(MDU_LAT);
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign hz.stall    = stall;
    assign hz.bubble   = stall || flush;
    assign hz.mdu_busy = mdu_busy;

    // Retiring-entry fields (e.g. load/mdu at writeback) have no reader.
    assign sb_unused = ^sb_q;
endmodule

// File: tb/tb_haz_scoreboard.sv
// Directed bench for haz_scoreboard: age-based in-flight model checked every cycle plus literal pins.
module tb_haz_scoreboard;
    localparam int REG_W     = 5;
    localparam int DEPTH     = 4;
    localparam int JMP_STAGE = 2;
    localparam int MDU_LAT   = 4;
    localparam int SEL_W     = $clog2(DEPTH + 1);
    localparam int LIFE      = (DEPTH > JMP_STAGE + MDU_LAT - 1) ? DEPTH : JMP_STAGE + MDU_LAT - 1;
`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit               vld, rs_vld, rt_vld, dst_vld, load, mop, mrd;
        logic [REG_W-1:0] rs, rt, dst;
    } dec_t;

    typedef struct {
        bit               wr;
        logic [REG_W-1:0] dst;
        bit               load;
        bit               mdu;
        int               age;
    } rec_t;

    typedef struct {
        int stall, bubble, rs_sel, rt_sel, busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    rec_t q[$];

    haz_scoreboard_if #(.REG_W(REG_W), .SEL_W(SEL_W)) hz();

    haz_scoreboard #(
        .REG_W(REG_W), .DEPTH(DEPTH), .JMP_STAGE(JMP_STAGE), .MDU_LAT(MDU_LAT), .SEL_W(SEL_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the list of in-flight instructions and their pipeline age.
    function automatic exp_t model_eval();
        exp_t e;
        int   rs_k = 0;
        int   rt_k = 0;
        bit   lu = 0, raw = 0, busy = 0, rs_on, rt_on;
        rs_on = hz.dec_vld && hz.dec_rs_vld && (hz.dec_rs != 0);
        rt_on = hz.dec_vld && hz.dec_rt_vld && (hz.dec_rt != 0);
        foreach (q[i]) begin
            int a;
            a = q[i].age;
            if (a <= DEPTH && q[i].wr) begin
                if (rs_on && q[i].dst == hz.dec_rs) begin
                    if (a < DEPTH) raw = 1;
                    if (a == 1 && q[i].load) lu = 1;
                    else if (a < DEPTH && (rs_k == 0 || a < rs_k)) rs_k = a;
                end
                if (rt_on && q[i].dst == hz.dec_rt) begin
                    if (a < DEPTH) raw = 1;
                    if (a == 1 && q[i].load) lu = 1;
                    else if (a < DEPTH && (rt_k == 0 || a < rt_k)) rt_k = a;
                end
            end
            if (q[i].mdu && a <= JMP_STAGE + MDU_LAT - 1) busy = 1;
        end
        e.busy   = int'(busy);
        e.stall  = int'(hz.dec_vld && !hz.mem_jmp_vld &&
                        (lu || ((hz.dec_mdu_rd || hz.dec_mdu_op) && busy) || (!FWD && raw)));
        e.bubble = int'(e.stall != 0 || hz.mem_jmp_vld);
        e.rs_sel = FWD ? rs_k : 0;
        e.rt_sel = FWD ? rt_k : 0;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        rec_t r;
        if (!rst_n) begin
            q.delete();
        end else begin
            e = model_eval();
            for (int i = q.size() - 1; i >= 0; i--)
                if (hz.mem_jmp_vld && q[i].age < JMP_STAGE) q.delete(i);
            foreach (q[i]) q[i].age = q[i].age + 1;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].age > LIFE) q.delete(i);
            if (hz.dec_vld && e.stall == 0 && !hz.mem_jmp_vld) begin
                r.wr   = hz.dec_dst_vld;
                r.dst  = hz.dec_dst;
                r.load = hz.dec_is_load;
                r.mdu  = hz.dec_mdu_op;
                r.age  = 1;
                q.push_back(r);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && cmp_en) begin
            e = model_eval();
            check("stall",      32'(hz.stall),      e.stall);
            check("bubble",     32'(hz.bubble),     e.bubble);
            check("fwd_rs_sel", 32'(hz.fwd_rs_sel), e.rs_sel);
            check("fwd_rt_sel", 32'(hz.fwd_rt_sel), e.rt_sel);
            check("mdu_busy",   32'(hz.mdu_busy),   e.busy);
        end
    end

    function automatic dec_t mk(bit rs_v, int rs, bit rt_v, int rt, bit dst_v, int dst,
                                bit ld, bit mop, bit mrd);
        dec_t d;
        d.vld = 1; d.rs_vld = rs_v; d.rt_vld = rt_v; d.dst_vld = dst_v;
        d.load = ld; d.mop = mop; d.mrd = mrd;
        d.rs = REG_W'(rs); d.rt = REG_W'(rt); d.dst = REG_W'(dst);
        return d;
    endfunction

    function automatic dec_t alu(int dst, int rs, int rt);
        return mk(1, rs, 1, rt, 1, dst, 0, 0, 0);
    endfunction

    function automatic dec_t lw(int dst, int base);
        return mk(1, base, 0, 0, 1, dst, 1, 0, 0);
    endfunction

    function automatic dec_t mult(int rs, int rt);
        return mk(1, rs, 1, rt, 0, 0, 0, 1, 0);
    endfunction

    function automatic dec_t mfhi(int dst);
        return mk(0, 0, 0, 0, 1, dst, 0, 0, 1);
    endfunction

    function automatic dec_t nop();
        dec_t d;
        d = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        d.vld = 0;
        return d;
    endfunction

    task automatic drive(input dec_t d, input bit jmp);
        hz.dec_vld     = d.vld;
        hz.dec_rs_vld  = d.rs_vld;
        hz.dec_rt_vld  = d.rt_vld;
        hz.dec_rs      = d.rs;
        hz.dec_rt      = d.rt;
        hz.dec_dst_vld = d.dst_vld;
        hz.dec_dst     = d.dst;
        hz.dec_is_load = d.load;
        hz.dec_mdu_op  = d.mop;
        hz.dec_mdu_rd  = d.mrd;
        hz.mem_jmp_vld = jmp;
    endtask

    // Hold d at decode until the model says it issues; called and returns just after a rising edge.
    task automatic run(input dec_t d, output int stalls);
        exp_t e;
        stalls = 0;
        drive(d, 0);
        for (int i = 0; i < 20; i++) begin
            #3;
            e = model_eval();
            @(posedge clk);
            #1;
            if (e.stall == 0) return;
            stalls++;
        end
        n_vec++;
        n_err++;
        $display("FAIL run_bound: instruction still stalled after %0d cycles, want issue", stalls);
    endtask

    task automatic idle(input int n);
        drive(nop(), 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal end");
        $fatal(1);
    end

    initial begin
        int s;
        drive(nop(), 0);
        #22;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        // Independent add right after reset.
        drive(alu(1, 2, 3), 0);
        #3;
        check("rst_stall",  32'(hz.stall), 0);
        check("rst_bubble", 32'(hz.bubble), 0);
        check("rst_rs_sel", 32'(hz.fwd_rs_sel), 0);
        check("rst_rt_sel", 32'(hz.fwd_rt_sel), 0);
        check("rst_busy",   32'(hz.mdu_busy), 0);
        @(posedge clk);
        #1;

        // add $5 then sub $6,$5,$5.
        run(alu(5, 2, 3), s);
        check("add5_stalls", s, 0);
        drive(alu(6, 5, 5), 0);
        #3;
        check("sub_rs_sel", 32'(hz.fwd_rs_sel), FWD ? 1 : 0);
        check("sub_rt_sel", 32'(hz.fwd_rt_sel), FWD ? 1 : 0);
        check("sub_stall0", 32'(hz.stall), FWD ? 0 : 1);
        run(alu(6, 5, 5), s);
        check("sub_stalls", s, FWD ? 0 : 3);

        // lw $4 then add $7,$4,$0.
        idle(4);
        run(lw(4, 2), s);
        check("lw_stalls", s, 0);
        drive(alu(7, 4, 0), 0);
        #3;
        check("lu_stall",  32'(hz.stall), 1);
        check("lu_bubble", 32'(hz.bubble), 1);
        @(posedge clk);
        #1;
        drive(alu(7, 4, 0), 0);
        #3;
        check("lu_next_stall",  32'(hz.stall), FWD ? 0 : 1);
        check("lu_next_rs_sel", 32'(hz.fwd_rs_sel), FWD ? 2 : 0);
        check("lu_next_rt_sel", 32'(hz.fwd_rt_sel), 0);
        run(alu(7, 4, 0), s);
        check("lu_rest_stalls", s, FWD ? 0 : 2);

        // Write to $0 then read $0.
        idle(4);
        run(alu(0, 1, 1), s);
        drive(alu(8, 0, 0), 0);
        #3;
        check("r0_stall",  32'(hz.stall), 0);
        check("r0_rs_sel", 32'(hz.fwd_rs_sel), 0);
        check("r0_rt_sel", 32'(hz.fwd_rt_sel), 0);
        run(alu(8, 0, 0), s);
        check("r0_stalls", s, 0);

        // mult then mfhi.
        idle(4);
        run(mult(1, 2), s);
        check("mult_stalls", s, 0);
        drive(mfhi(9), 0);
        #3;
        check("mfhi_busy",  32'(hz.mdu_busy), 1);
        check("mfhi_stall", 32'(hz.stall), 1);
        run(mfhi(9), s);
        check("mfhi_stalls", s, JMP_STAGE + MDU_LAT - 1);
        drive(nop(), 0);
        #3;
        check("mfhi_busy_done", 32'(hz.mdu_busy), 0);
        @(posedge clk);
        #1;

        // Flush with a load in entry 1 and its consumer at decode.
        idle(4);
        run(lw(4, 2), s);
        drive(alu(7, 4, 0), 1);
        #3;
        check("fl_bubble", 32'(hz.bubble), 1);
        check("fl_stall",  32'(hz.stall), 0);
        @(posedge clk);
        #1;
        drive(alu(7, 4, 0), 0);
        #3;
        check("fl_next_stall",  32'(hz.stall), 0);
        check("fl_next_rs_sel", 32'(hz.fwd_rs_sel), 0);
        run(alu(7, 4, 0), s);
        check("fl_stalls", s, 0);

        // Flush drops an MDU op that has not reached the jump stage.
        idle(4);
        run(mult(1, 2), s);
        drive(nop(), 1);
        #3;
        check("flm_busy", 32'(hz.mdu_busy), 1);
        @(posedge clk);
        #1;
        drive(nop(), 0);
        #3;
        check("flm_busy_after", 32'(hz.mdu_busy), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-MDU with producers in flight.
        idle(4);
        run(mult(1, 2), s);
        run(alu(9, 1, 2), s);
        run(alu(10, 1, 2), s);
        drive(mk(1, 9, 1, 10, 1, 11, 0, 0, 1), 0);
        #3;
        check("pre_rst_busy",   32'(hz.mdu_busy), 1);
        check("pre_rst_stall",  32'(hz.stall), 1);
        check("pre_rst_rs_sel", 32'(hz.fwd_rs_sel), FWD ? 2 : 0);
        check("pre_rst_rt_sel", 32'(hz.fwd_rt_sel), FWD ? 1 : 0);
        rst_n = 1'b0;
        #1;
        check("in_rst_stall",  32'(hz.stall), 0);
        check("in_rst_bubble", 32'(hz.bubble), 0);
        check("in_rst_rs_sel", 32'(hz.fwd_rs_sel), 0);
        check("in_rst_rt_sel", 32'(hz.fwd_rt_sel), 0);
        check("in_rst_busy",   32'(hz.mdu_busy), 0);
        drive(nop(), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(alu(12, 9, 10), s);
        check("post_rst_stalls", s, 0);
        drive(alu(13, 12, 0), 0);
        #3;
        check("post_rst_rs_sel", 32'(hz.fwd_rs_sel), FWD ? 1 : 0);
        check("post_rst_stall",  32'(hz.stall), FWD ? 0 : 1);
        run(alu(13, 12, 0), s);
        check("post_rst_dep_stalls", s, FWD ? 0 : 3);

        idle(6);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
